// File: rtl/param_rr_arb.sv
// param_rr_arb - round-robin arbiter for one shared resource.
//
// Grants one of req_width requesters at a time. The grant is a registered
// one-hot bus with a binary index of the winner. A grant is held until the
// owner acks or drops its request. After that there is at least one idle
// cycle before the next grant. The search for the next winner starts just
// after the previous winner.
//
// Optional build macro: PARAM_RR_ARB_TIMEOUT_EN
//   When defined, a hold counter forces a release once a grant has been held
//   for timeout_cycles cycles, and pulses timeout for one cycle.
//   When undefined, grants are held indefinitely and timeout is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   req          in   [req_width]  level-sensitive requests
//   ack          in   owner done; only looked at while a grant is held
//   grant        out  [req_width]  registered one-hot grant, zero when idle
//   grant_idx    out  [idx_width]  index of the current or last winner
//   grant_valid  out  high while a grant is held
//   timeout      out  one-cycle pulse on a forced release
//
// States:
//   IDLE | no grant held; arbitrate whenever any req is set
//   BUSY | grant held until ack, owner drops req, or (optionally) timeout

module param_rr_arb #(
  parameter int req_width      = 4,
  parameter int idx_width      = 2,
  parameter int timeout_cycles = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [req_width-1:0] req,
  input  logic                 ack,
  output logic [req_width-1:0] grant,
  output logic [idx_width-1:0] grant_idx,
  output logic                 grant_valid,
  output logic                 timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [req_width-1:0] grant_q, grant_d;
  logic [idx_width-1:0] grant_idx_q, grant_idx_d;
  logic [idx_width-1:0] last_idx_q, last_idx_d;

  logic [idx_width-1:0] sel_idx;
  logic [req_width-1:0] sel_onehot;
  logic                 owner_done;

  // Round-robin pick. A requester above last_idx wins over one at or below
  // it. Within each group the lowest index wins. Walking the bits from high
  // to low leaves the lowest match in each group. Because only real bit
  // positions are scanned, the wrap is modulo req_width.
  logic                 hi_found;
  logic [idx_width-1:0] hi_idx;
  logic [idx_width-1:0] lo_idx;

  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = req_width - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_idx = idx_width'(j);
        if (j > int'(last_idx_q)) begin
          hi_found = 1'b1;
          hi_idx   = idx_width'(j);
        end
      end
    end
    sel_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_onehot = '0;
    for (int j = 0; j < req_width; j++) begin
      sel_onehot[j] = (idx_width'(j) == sel_idx);
    end
  end

  // Masking req with the registered grant avoids indexing req by grant_idx.
  // That indexing would be out of range if req_width < 2**idx_width.
  assign owner_done = ack || ((req & grant_q) == '0);

`ifdef PARAM_RR_ARB_TIMEOUT_EN
  localparam int CNT_W = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(timeout_cycles - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
`ifdef PARAM_RR_ARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = BUSY;
          grant_d     = sel_onehot;
          grant_idx_d = sel_idx;
          last_idx_d  = sel_idx;
`ifdef PARAM_RR_ARB_TIMEOUT_EN
          hold_cnt_d  = '0;
`endif
        end
      end
      BUSY: begin
        // A normal release has priority, so it never raises timeout.
        if (owner_done) begin
          state_d = IDLE;
          grant_d = '0;
`ifdef PARAM_RR_ARB_TIMEOUT_EN
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      last_idx_q  <= idx_width'(req_width - 1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
    end
  end

`ifdef PARAM_RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = (state_q == BUSY);

endmodule

// File: tb/tb_param_rr_arb.sv
module tb_param_rr_arb;

  localparam int W  = 4;
  localparam int IW = 2;
  localparam int TC = 16;
`ifdef PARAM_RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  req = '0;
  logic          ack = 1'b0;
  logic [W-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          timeout;

  int n_cmp = 0;
  int n_bad = 0;

  param_rr_arb #(
    .req_width(W), .idx_width(IW), .timeout_cycles(TC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .grant(grant), .grant_idx(grant_idx),
    .grant_valid(grant_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // The model tracks who holds the grant, who won last, and how long the grant has been held.
  int m_valid = 0;
  int m_idx   = 0;
  int m_last  = W - 1;
  int m_hold  = 0;
  int m_to    = 0;

  always @(posedge clk or posedge rst) begin : model
    int  nxt;
    bit  found;
    if (rst) begin
      m_valid <= 0; m_idx <= 0; m_last <= W - 1; m_hold <= 0; m_to <= 0;
    end else if (m_valid == 0) begin
      m_to <= 0;
      found = 1'b0;
      nxt   = 0;
      for (int k = 1; k <= W; k++) begin
        if (!found && req[(m_last + k) % W]) begin
          found = 1'b1;
          nxt   = (m_last + k) % W;
        end
      end
      if (found) begin
        m_valid <= 1; m_idx <= nxt; m_last <= nxt; m_hold <= 1;
      end
    end else if (ack || !req[m_idx]) begin
      m_valid <= 0; m_to <= 0;
    end else if (TO_EN && m_hold == TC) begin
      m_valid <= 0; m_to <= 1;
    end else begin
      m_hold <= m_hold + 1; m_to <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("mdl_grant", grant, m_valid ? (32'd1 << m_idx) : 32'd0);
      check("mdl_valid", grant_valid, m_valid);
      check("mdl_idx", grant_idx, m_idx);
      check("mdl_timeout", timeout, m_to);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  int exp_seq[5] = '{0, 1, 2, 3, 0};
  int held;
  bit saw_to;

  initial begin
    rst = 1'b1;
    tick(); tick();
    #1;
    check("rst_grant", grant, 0);
    check("rst_valid", grant_valid, 0);
    check("rst_idx", grant_idx, 0);
    check("rst_timeout", timeout, 0);
    tick();
    rst = 1'b0;

    // 1: req=1010. Requester 1 wins first. After the ack and one dead cycle, requester 3 wins.
    req = 4'b1010;
    tick();
    check("t1_grant", grant, 4'b0010);
    check("t1_idx", grant_idx, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_hold", grant, 4'b0010);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t1_dead", grant, 4'b0000);
    tick();
    check("t1_next", grant, 4'b1000);
    check("t1_next_idx", grant_idx, 3);
    req = 4'b0000;
    tick();
    check("t1_idle", grant_valid, 0);
    check("t1_idx_keep", grant_idx, 3);

    // 2: all four requesters request. Grants must rotate 0,1,2,3,0, each followed by one dead cycle.
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("t2_idx", grant_idx, exp_seq[g]);
      check("t2_valid", grant_valid, 1);
      ack = 1'b1;
      if (g == 4) req = 4'b0000;
      tick();
      ack = 1'b0;
      check("t2_dead", grant, 0);
    end

    // 3: the owner drops its request without an ack. The pending requester 3 wins next.
    req = 4'b1100;
    tick();
    check("t3_grant", grant, 4'b0100);
    req = 4'b1000;
    tick();
    check("t3_drop", grant, 0);
    tick();
    check("t3_next", grant, 4'b1000);
    req = 4'b0000;
    tick();

    // 4: async reset between edges while requester 2 holds the grant.
    req = 4'b0100;
    tick();
    check("t4_pre", grant, 4'b0100);
    #2 rst = 1'b1;
    #1;
    check("t4_async_grant", grant, 0);
    check("t4_async_valid", grant_valid, 0);
    req = 4'b0110;
    tick();
    rst = 1'b0;
    tick();
    check("t4_first", grant, 4'b0010);
    check("t4_first_idx", grant_idx, 1);
    ack = 1'b1;
    req = 4'b0000;
    tick();
    ack = 1'b0;

    // 5: requester 0 alone. It is regranted after each single dead cycle.
    req = 4'b0001;
    for (int g = 0; g < 4; g++) begin
      tick();
      check("t5_grant", grant, 4'b0001);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("t5_dead", grant, 0);
    end
    req = 4'b0000;
    tick();

    // 6: hold a grant with no ack. Timeout builds force a release; default builds hold indefinitely.
    req = 4'b0001;
    tick();
    held   = 0;
    saw_to = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (grant_valid !== 1'b1) break;
      held++;
      if (timeout === 1'b1) saw_to = 1'b1;
      tick();
    end
`ifdef PARAM_RR_ARB_TIMEOUT_EN
    check("t6_held", held, TC);
    check("t6_pulse", timeout, 1);
    check("t6_dead", grant, 0);
    tick();
    check("t6_regrant", grant, 4'b0001);
    check("t6_pulse_end", timeout, 0);
`else
    check("t6_held", held, 120);
    check("t6_still", grant, 4'b0001);
    check("t6_no_to", saw_to, 0);
    check("t6_to_now", timeout, 0);
`endif
    ack = 1'b1;
    req = 4'b0000;
    tick();
    ack = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1, "watchdog");
  end

endmodule
